// File: rtl/capture_ctrl.sv
// capture_ctrl: arms on request, watches undelayed probe data for a masked
// trigger match, streams delayed samples into a circular RAM and stops after
// a bounded number of post-trigger samples.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | not capturing; waits for arm
// PRETRIG  | writing delayed samples, comparing undelayed data for trigger
// POSTTRIG | trigger seen; writing remaining delay + post-trigger samples
// DONE     | capture complete; trig_addr/wrapped held for readout
module capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DELAY      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  wrapped,
  output logic                  done,
  output logic [1:0]            state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DLY    = ADDR_WIDTH'(DELAY);
  // Largest post-trigger count that keeps the trigger entry from being overwritten.
  localparam logic [ADDR_WIDTH-1:0] PC_MAX = ADDR_WIDTH'(DEPTH - 1 - DELAY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRETRIG  = 2'd1,
    POSTTRIG = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  done_q, done_d;

  logic                  match;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] total;

  assign match = ((i_data ^ trig_value) & trig_mask) == '0;
  assign pc    = (post_count > PC_MAX) ? PC_MAX : post_count;
  assign total = DLY + pc;

  // Next-state and registered-output logic; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    wrapped_d   = wrapped_q;
    done_d      = done_q;
    capture     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d   = PRETRIG;
            ptr_d     = '0;
            wrapped_d = 1'b0;
            done_d    = 1'b0;
          end
        end
        PRETRIG: begin
          capture = 1'b1;
          if (match) begin
            trig_addr_d = ptr_q + DLY;
            if (total == '0) begin
              state_d = DONE;
            end else begin
              rem_d   = total;
              state_d = POSTTRIG;
            end
          end
        end
        POSTTRIG: begin
          capture = 1'b1;
          if (rem_q == ADDR_WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            rem_d = rem_q - ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          done_d = 1'b1;
          if (arm) begin
            state_d   = PRETRIG;
            ptr_d     = '0;
            wrapped_d = 1'b0;
            done_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (capture) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = d_data;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == '1) begin
          wrapped_d = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      wrapped_q   <= wrapped_d;
      done_q      <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign trig_addr = trig_addr_q;
  assign wrapped   = wrapped_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule
